// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types and defaults for the memory instruction queue.
// Instructions use ascending bit numbering: bit 0 is the MSB, and the
// opcode occupies bits [0:OPCODE_WIDTH-1].
package gpu_pkg;

  localparam int OPCODE_WIDTH          = 4;
  localparam int DEF_INSTRUCTION_WIDTH = 32;
  localparam int DEF_WORD_WIDTH        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    WAIT  = 2'd3
  } queue_state_t;

  // Extracts the opcode field from a default-width instruction word.
  function automatic logic [OPCODE_WIDTH-1:0] opcode_of(
    input logic [0:DEF_INSTRUCTION_WIDTH-1] instr
  );
    return instr[0:OPCODE_WIDTH-1];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular buffer with registered occupancy.
// Pushes while full and pops while empty are ignored. DEPTH must be a
// power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push_in,
  input  logic                       pop_in,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_out  = (r_count == CNT_FULL);
  assign empty_out = (r_count == '0);
  assign count_out = r_count;
  assign data_out  = r_mem[r_rd_ptr];
  assign w_do_push = push_in && !full_out;
  assign w_do_pop  = pop_in && !empty_out;

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk_in) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/memory_instr_queue.sv
// memory_instr_queue: buffers memory instructions plus operands and issues
// them one at a time to the memory whenever it reports idle.
// Optional build macro: QUEUE_BYPASS_EN -- a push into an empty queue with
// the FSM idle and memory idle skips storage and issues one cycle earlier.
//
// state | meaning
// IDLE  | waiting for a queued entry and an idle memory; pops on exit
// ISSUE | instr_valid_out strobe cycle; loads the holdoff counter
// HOLD  | memory_idle_in ignored while the holdoff counter runs down
// WAIT  | waiting for memory_idle_in before returning to IDLE
module memory_instr_queue
  import gpu_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter int WORD_WIDTH        = DEF_WORD_WIDTH,
  parameter int DEPTH             = 8,
  parameter int HOLDOFF           = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [0:INSTRUCTION_WIDTH-1] instr_in,
  input  logic [WORD_WIDTH-1:0]        reg_a_in,
  input  logic [WORD_WIDTH-1:0]        reg_b_in,
  input  logic [WORD_WIDTH-1:0]        reg_c_in,
  input  logic                         instr_valid_in,
  output logic                         ready_out,
  input  logic                         memory_idle_in,
  output logic [0:INSTRUCTION_WIDTH-1] instr_out,
  output logic [WORD_WIDTH-1:0]        reg_a_out,
  output logic [WORD_WIDTH-1:0]        reg_b_out,
  output logic [WORD_WIDTH-1:0]        reg_c_out,
  output logic                         instr_valid_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic                         overflow_out
);

  localparam int ENTRY_WIDTH = INSTRUCTION_WIDTH + 3*WORD_WIDTH;
  localparam int CW          = $clog2(DEPTH+1);
  localparam int HOLD_WIDTH  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  // ISSUE plus HOLDOFF-1 HOLD cycles gives HOLDOFF cycles of ignored idle.
  localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(HOLDOFF - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(1);

  queue_state_t r_state;
  queue_state_t w_next_state;

  logic [HOLD_WIDTH-1:0]        r_hold_cnt;
  logic                         r_issue_valid;
  logic [0:INSTRUCTION_WIDTH-1] r_instr;
  logic [WORD_WIDTH-1:0]        r_reg_a;
  logic [WORD_WIDTH-1:0]        r_reg_b;
  logic [WORD_WIDTH-1:0]        r_reg_c;
  logic                         r_overflow;

  logic [ENTRY_WIDTH-1:0] w_entry_in;
  logic [ENTRY_WIDTH-1:0] w_fifo_rdata;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [CW-1:0]          w_fifo_count;
  logic                   w_push;
  logic                   w_fifo_push;
  logic                   w_pop;
  logic                   w_bypass;

  assign w_entry_in = {instr_in, reg_a_in, reg_b_in, reg_c_in};
  assign ready_out  = !w_fifo_full;
  assign w_push     = instr_valid_in && ready_out;
  assign w_pop      = (r_state == IDLE) && !w_fifo_empty && memory_idle_in;

`ifdef QUEUE_BYPASS_EN
  assign w_bypass   = w_push && w_fifo_empty && (r_state == IDLE) && memory_idle_in;
`else
  assign w_bypass   = 1'b0;
`endif

  assign w_fifo_push = w_push && !w_bypass;

  sync_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (w_fifo_push),
    .pop_in    (w_pop),
    .data_in   (w_entry_in),
    .data_out  (w_fifo_rdata),
    .full_out  (w_fifo_full),
    .empty_out (w_fifo_empty),
    .count_out (w_fifo_count)
  );

  assign instr_out       = r_instr;
  assign reg_a_out       = r_reg_a;
  assign reg_b_out       = r_reg_b;
  assign reg_c_out       = r_reg_c;
  assign instr_valid_out = r_issue_valid;
  assign count_out       = w_fifo_count;
  assign overflow_out    = r_overflow;

  // Next-state decode for the issue sequencer.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_pop || w_bypass) w_next_state = ISSUE;
      ISSUE:   w_next_state = HOLD;
      HOLD:    if (r_hold_cnt <= HOLD_LAST) w_next_state = WAIT;
      WAIT:    if (memory_idle_in) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Holdoff down-counter: loaded in ISSUE, decremented through HOLD.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_hold_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_hold_cnt <= HOLD_LOAD;
    end else if (r_state == HOLD && r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  // Issue registers: capture the popped (or bypassed) entry; hold otherwise.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_issue_valid <= 1'b0;
      r_instr       <= '0;
      r_reg_a       <= '0;
      r_reg_b       <= '0;
      r_reg_c       <= '0;
    end else begin
      r_issue_valid <= w_pop || w_bypass;
      if (w_pop) begin
        {r_instr, r_reg_a, r_reg_b, r_reg_c} <= w_fifo_rdata;
      end else if (w_bypass) begin
        {r_instr, r_reg_a, r_reg_b, r_reg_c} <= w_entry_in;
      end
    end
  end

  // Sticky overflow: any push attempted while full is dropped and flagged.
  always_ff @(posedge clk_in) begin
    if (rst_in)                           r_overflow <= 1'b0;
    else if (instr_valid_in && !ready_out) r_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_memory_instr_queue.sv
// Testbench for memory_instr_queue: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// queue-based reference model.
module tb_memory_instr_queue;
  import gpu_pkg::*;

  localparam int IW      = 32;
  localparam int WW      = 16;
  localparam int DEPTH   = 8;
  localparam int HOLDOFF = 2;
  localparam int CW      = $clog2(DEPTH+1);

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [0:IW-1] instr_in;
  logic [WW-1:0] reg_a_in, reg_b_in, reg_c_in;
  logic          instr_valid_in;
  logic          ready_out;
  logic          memory_idle_in;
  logic [0:IW-1] instr_out;
  logic [WW-1:0] reg_a_out, reg_b_out, reg_c_out;
  logic          instr_valid_out;
  logic [CW-1:0] count_out;
  logic          overflow_out;

  always #5 clk_in = ~clk_in;

  memory_instr_queue #(
    .INSTRUCTION_WIDTH (IW),
    .WORD_WIDTH        (WW),
    .DEPTH             (DEPTH),
    .HOLDOFF           (HOLDOFF)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .instr_in        (instr_in),
    .reg_a_in        (reg_a_in),
    .reg_b_in        (reg_b_in),
    .reg_c_in        (reg_c_in),
    .instr_valid_in  (instr_valid_in),
    .ready_out       (ready_out),
    .memory_idle_in  (memory_idle_in),
    .instr_out       (instr_out),
    .reg_a_out       (reg_a_out),
    .reg_b_out       (reg_b_out),
    .reg_c_out       (reg_c_out),
    .instr_valid_out (instr_valid_out),
    .count_out       (count_out),
    .overflow_out    (overflow_out)
  );

  typedef struct {
    logic [IW-1:0] instr;
    logic [WW-1:0] a;
    logic [WW-1:0] b;
    logic [WW-1:0] c;
  } ent_t;

  // Reference model: a plain queue of entries plus issue-window bookkeeping.
  ent_t mq[$];
  bit   m_released;
  int   m_last_issue;
  bit   m_ovf;
  bit   m_valid;
  ent_t m_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int            dut_iss_cyc[$];
  logic [IW-1:0] dut_iss_instr[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advances the model by the inputs of cycle 'cyc' (sampled at this edge).
  task automatic model_edge();
    bit   rdy, pop, byp, mem_idle;
    ent_t e_in;
    if (rst_in) begin
      mq.delete();
      m_released   = 1'b1;
      m_last_issue = -100;
      m_ovf        = 1'b0;
      m_valid      = 1'b0;
      m_out        = '{instr: '0, a: '0, b: '0, c: '0};
      return;
    end
    mem_idle = memory_idle_in;
    rdy      = (mq.size() != DEPTH);
    e_in     = '{instr: instr_in, a: reg_a_in, b: reg_b_in, c: reg_c_in};
    pop      = m_released && (mq.size() > 0) && mem_idle;
    byp      = 1'b0;
`ifdef QUEUE_BYPASS_EN
    byp      = m_released && (mq.size() == 0) && mem_idle && instr_valid_in && rdy;
`endif
    m_valid = pop || byp;
    if (pop) m_out = mq.pop_front();
    if (instr_valid_in && rdy) begin
      if (byp) m_out = e_in;
      else     mq.push_back(e_in);
    end
    if (instr_valid_in && !rdy) m_ovf = 1'b1;
    // After an issue in cycle s, idle is ignored until cycle s+HOLDOFF;
    // the first idle cycle from then on re-enables popping the next cycle.
    if (pop || byp) begin
      m_released   = 1'b0;
      m_last_issue = cyc + 1;
    end else if (!m_released && cyc >= m_last_issue + HOLDOFF && mem_idle) begin
      m_released = 1'b1;
    end
  endtask

  task automatic compare();
    check("valid",    instr_valid_out, m_valid);
    check("ready",    ready_out,       mq.size() != DEPTH);
    check("count",    count_out,       mq.size());
    check("overflow", overflow_out,    m_ovf);
    check("instr",    instr_out,       m_out.instr);
    check("reg_a",    reg_a_out,       m_out.a);
    check("reg_b",    reg_b_out,       m_out.b);
    check("reg_c",    reg_c_out,       m_out.c);
    if (instr_valid_out === 1'b1) begin
      dut_iss_cyc.push_back(cyc);
      dut_iss_instr.push_back(instr_out);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    cyc++;
    #1;
    compare();
  endtask

  task automatic drive(input bit v, input logic [IW-1:0] ins,
                       input logic [WW-1:0] a, input logic [WW-1:0] b, input logic [WW-1:0] c);
    instr_valid_in = v;
    instr_in       = ins;
    reg_a_in       = a;
    reg_b_in       = b;
    reg_c_in       = c;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    step();
    rst_in = 1'b0;
  endtask

  initial begin
    bit seen;
    int nv;
    rst_in         = 1'b1;
    memory_idle_in = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    step();
    step();
    rst_in = 1'b0;

    // Reset state
    check("rst_count", count_out, 0);
    check("rst_ready", ready_out, 1);
    check("rst_valid", instr_valid_out, 0);
    check("rst_ovf",   overflow_out, 0);
    check("rst_instr", instr_out, 0);

    // Single issue
    memory_idle_in = 1'b1;
    drive(1'b1, 32'h1000_0005, 16'd3, 16'd4, 16'd7);
    step();
    drive(1'b0, '0, '0, '0, '0);
`ifdef QUEUE_BYPASS_EN
    check("single_valid_n1", instr_valid_out, 1);
    check("single_instr",    instr_out, 32'h1000_0005);
    check("single_count_n1", count_out, 0);
    step();
    check("single_valid_n2", instr_valid_out, 0);
`else
    check("single_valid_n1", instr_valid_out, 0);
    check("single_count_n1", count_out, 1);
    step();
    check("single_valid_n2", instr_valid_out, 1);
    check("single_instr",    instr_out, 32'h1000_0005);
    check("single_a",        reg_a_out, 3);
    check("single_b",        reg_b_out, 4);
    check("single_c",        reg_c_out, 7);
    check("single_count_n2", count_out, 0);
`endif
    repeat (6) step();
    check("single_hold_instr", instr_out, 32'h1000_0005);

    // Overflow
    do_reset();
    memory_idle_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h2000_0000 + i, 16'(i), 16'(i + 1), 16'(i + 2));
      step();
      if (i == 7) begin
        check("ovf_ready_full", ready_out, 0);
        check("ovf_count_full", count_out, 8);
        check("ovf_flag_early", overflow_out, 0);
      end
    end
    drive(1'b0, '0, '0, '0, '0);
    check("ovf_flag",  overflow_out, 1);
    check("ovf_count", count_out, 8);
    memory_idle_in = 1'b1;
    dut_iss_cyc.delete();
    dut_iss_instr.delete();
    repeat (40) step();
    check("ovf_drained_n", dut_iss_instr.size(), 8);
    if (dut_iss_instr.size() == 8) check("ovf_last_instr", dut_iss_instr[7], 32'h2000_0007);
    check("ovf_sticky", overflow_out, 1);

    // Ordering and spacing
    do_reset();
    memory_idle_in = 1'b1;
    dut_iss_cyc.delete();
    dut_iss_instr.delete();
    drive(1'b1, 32'h0000_000A, 16'h1, 16'h2, 16'h3); step();
    drive(1'b1, 32'h0000_000B, 16'h4, 16'h5, 16'h6); step();
    drive(1'b1, 32'h0000_000C, 16'h7, 16'h8, 16'h9); step();
    drive(1'b0, '0, '0, '0, '0);
    repeat (14) step();
    check("ord_n", dut_iss_cyc.size(), 3);
    if (dut_iss_cyc.size() == 3) begin
      check("ord_a",      dut_iss_instr[0], 32'hA);
      check("ord_b",      dut_iss_instr[1], 32'hB);
      check("ord_c",      dut_iss_instr[2], 32'hC);
      check("ord_gap_ab", dut_iss_cyc[1] - dut_iss_cyc[0], 4);
      check("ord_gap_bc", dut_iss_cyc[2] - dut_iss_cyc[1], 4);
    end

    // Wait on busy memory
    do_reset();
    memory_idle_in = 1'b1;
    drive(1'b1, 32'h3000_0001, 16'h11, 16'h22, 16'h33);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      drive(1'b0, '0, '0, '0, '0);
      if (instr_valid_out === 1'b1) seen = 1'b1;
    end
    check("busy_first_issue", seen, 1);
    memory_idle_in = 1'b0;
    drive(1'b1, 32'h3000_0002, 16'h44, 16'h55, 16'h66);
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      drive(1'b0, '0, '0, '0, '0);
      if (instr_valid_out === 1'b1) nv++;
    end
    check("busy_no_issue", nv, 0);
    memory_idle_in = 1'b1;
    step();
    check("busy_rise_p1", instr_valid_out, 0);
    step();
    check("busy_rise_p2", instr_valid_out, 1);
    check("busy_instr",   instr_out, 32'h3000_0002);
    repeat (5) step();

    // Reset mid-operation
    do_reset();
    memory_idle_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h4000_0000 + i, 16'(i), 16'(i), 16'(i));
      step();
    end
    drive(1'b0, '0, '0, '0, '0);
    check("midrst_pre_count", count_out, 5);
    do_reset();
    check("midrst_count", count_out, 0);
    check("midrst_valid", instr_valid_out, 0);
    check("midrst_ovf",   overflow_out, 0);
    memory_idle_in = 1'b1;
    dut_iss_instr.delete();
    dut_iss_cyc.delete();
    drive(1'b1, 32'h5000_0009, 16'h9, 16'h9, 16'h9);
    step();
    drive(1'b0, '0, '0, '0, '0);
    repeat (4) step();
    check("midrst_reissue_n", dut_iss_instr.size(), 1);
    if (dut_iss_instr.size() == 1) check("midrst_reissue", dut_iss_instr[0], 32'h5000_0009);

    // Randomized traffic with alternating fill/drain bias and rare resets
    for (int i = 0; i < 3000; i++) begin
      int idle_pct;
      idle_pct = ((i / 200) % 2 == 0) ? 15 : 70;
      rst_in         = ($urandom_range(0, 399) == 0);
      memory_idle_in = ($urandom_range(0, 99) < idle_pct);
      drive($urandom_range(0, 99) < 55, $urandom, 16'($urandom), 16'($urandom), 16'($urandom));
      step();
    end
    rst_in = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_instr_queue.md
Name: memory_instr_queue

Overview:
- Buffers memory-bound instructions and their register operands between controller and memory.
- Controller pushes whenever `ready_out` is high, so it never stalls on a busy memory.
- Queue issues one entry at a time, only when `memory_idle_in` reports memory idle.
- Drives the memory's `instr_in`, `instr_valid_in` and `controller_reg_a/b/c` inputs directly.

Parameters:
- INSTRUCTION_WIDTH, 32, instruction word width; bit 0 is MSB, opcode is bits [0:3].
- WORD_WIDTH, 16, width of each register operand.
- DEPTH, 8, number of queue entries; must be a power of two, at least 2.
- HOLDOFF, 2, cycles after an issue during which `memory_idle_in` is ignored.

Ports:
- clk_in  input  1  system clock; one clock domain.
- rst_in  input  1  synchronous, active-high reset.
- instr_in  input  [0:INSTRUCTION_WIDTH-1]  instruction from controller.
- reg_a_in / reg_b_in / reg_c_in  input  WORD_WIDTH each  operands captured with the instruction.
- instr_valid_in  input  1  push request.
- ready_out  output  1  queue not full.
- memory_idle_in  input  1  memory is idle and can take an instruction.
- instr_out  output  [0:INSTRUCTION_WIDTH-1]  issued instruction.
- reg_a_out / reg_b_out / reg_c_out  output  WORD_WIDTH each  issued operands.
- instr_valid_out  output  1  single-cycle issue strobe.
- count_out  output  $clog2(DEPTH+1)  current occupancy.
- overflow_out  output  1  sticky flag: a push was dropped.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; `ready_out` is 1 in the cycle after reset.
  - Pointers and count cleared; FSM goes to IDLE.
  - Reset mid-operation discards queued entries; an already-issued instruction is not retracted.
- Storage:
  - Entry = {instr, reg_a, reg_b, reg_c}, written in one cycle.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Push rule:
  - Push occurs when `instr_valid_in && ready_out`.
  - `ready_out` = (count != DEPTH), derived from registered count.
  - Push while full: entry dropped, `overflow_out` set and held until reset.
  - This holds even if a pop occurs in the same cycle.
- Pop rule: pop occurs only on the IDLE→ISSUE transition.
- Simultaneous push and pop: count unchanged; both pointers advance.
- FSM states:
  - IDLE: if count>0 and `memory_idle_in`=1, pop the head, register it onto the outputs, go to ISSUE.
  - ISSUE: `instr_valid_out`=1 for exactly this cycle; load hold counter with HOLDOFF-1; go to HOLD.
  - HOLD: decrement the hold counter; `memory_idle_in` is ignored; at 0 go to WAIT.
  - WAIT: stay until `memory_idle_in`=1, then go to IDLE.
- Issue throughput: back-to-back issues are spaced at least HOLDOFF+2 cycles apart.
- Output holding:
  - `instr_out` and `reg_*_out` hold the last issued values until the next issue.
  - They are never zeroed between issues.
- Latency: push at cycle N into an empty queue with memory idle → `instr_valid_out` at cycle N+2.
  - N+1: IDLE sees count=1 and pops.
  - N+2: ISSUE.
- Ordering: strict FIFO; no opcode inspection, no reordering.
- `count_out` is registered and updates the cycle after a push or pop.

Optional Feature:
- Macro: QUEUE_BYPASS_EN.
- Defined:
  - Condition: queue empty, FSM in IDLE, `memory_idle_in`=1 and a push arrives.
  - Action: the entry skips storage, is registered directly to the outputs, and the FSM goes to ISSUE. Issue latency becomes N+1.
  - `count_out` stays 0.
  - The push is still counted for `ready_out` purposes (always ready in this case).
- Undefined: every push goes through storage; N+2 latency as specified above.

Decomposition:
- Shared package `gpu_pkg` holds:
  - the `queue_state_t` enum {IDLE, ISSUE, HOLD, WAIT};
  - OPCODE_WIDTH=4;
  - INSTRUCTION_WIDTH and WORD_WIDTH defaults.
- Sub-module `sync_fifo` (parameterised width/depth):
  - ports: push, pop, data, full/empty/count;
  - entry width = INSTRUCTION_WIDTH + 3*WORD_WIDTH.
- FSM and issue registers stay in `memory_instr_queue`.

Test Plan:
- Single issue:
  - Stimulus: after reset, push instr 0x1000_0005 with a=3, b=4, c=7; `memory_idle_in`=1.
  - Response: `instr_valid_out` pulses once at N+2 with exactly those values; `count_out` goes 1 then 0.
- Overflow, DEPTH=8:
  - Stimulus: `memory_idle_in`=0; push 9 entries.
  - Response: `ready_out` drops after 8 pushes; 9th push dropped; `overflow_out`=1; `count_out`=8.
- Ordering and spacing:
  - Stimulus: push 3 entries (0xA, 0xB, 0xC); `memory_idle_in` held at 1.
  - Response: issues in order A, B, C, each 4 cycles apart (HOLDOFF=2).
- Wait on busy memory:
  - Stimulus: after an issue, drive `memory_idle_in`=0 for 20 cycles.
  - Response: no further issue until `memory_idle_in`=1; next strobe follows 2 cycles after it rises.
- Reset mid-operation:
  - Stimulus: 5 queued entries, assert `rst_in` for 1 cycle.
  - Response: `count_out`=0, `instr_valid_out`=0, `overflow_out`=0; the next push issues normally.
- Bypass (QUEUE_BYPASS_EN defined):
  - Stimulus: push into an empty queue with memory idle.
  - Response: `instr_valid_out` at N+1; `count_out` remains 0.
